// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto a single shared memory port.
// Round-robin tie break, per-access timeout, all outputs registered.
module mem_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic [63:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [63:0] d_wdata,
  input  logic [1:0]  d_tam,
  output logic        d_gnt,
  output logic [63:0] d_rdata,
  output logic        d_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [1:0]  mem_tam,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10,
    RESP   = 2'b11
  } state_t;

  localparam logic [3:0] TIMEOUT_C = 4'(TIMEOUT);
  localparam logic       PORT_I    = 1'b0;
  localparam logic       PORT_D    = 1'b1;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  mem_tam_q, mem_tam_d;
  logic        i_gnt_q, i_gnt_d;
  logic        d_gnt_q, d_gnt_d;
  logic        i_done_q, i_done_d;
  logic        d_done_q, d_done_d;
  logic [63:0] i_rdata_q, i_rdata_d;
  logic [63:0] d_rdata_q, d_rdata_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        pick_d_s;

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_q      <= PORT_I;
      cnt_q       <= 4'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 64'd0;
      mem_tam_q   <= 2'b00;
      i_gnt_q     <= 1'b0;
      d_gnt_q     <= 1'b0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      i_rdata_q   <= 64'd0;
      d_rdata_q   <= 64'd0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_tam_q   <= mem_tam_d;
      i_gnt_q     <= i_gnt_d;
      d_gnt_q     <= d_gnt_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_tam_d   = mem_tam_q;
    i_gnt_d     = 1'b0;
    d_gnt_d     = 1'b0;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    err_d       = 1'b0;
    // On a tie the port that was not served last wins
    pick_d_s    = d_req & (~i_req | (last_q == PORT_I));

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          mem_req_d = 1'b1;
          cnt_d     = 4'd0;
          if (pick_d_s) begin
            state_d     = BUSY_D;
            d_gnt_d     = 1'b1;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_tam_d   = d_tam;
          end else begin
            state_d     = BUSY_I;
            i_gnt_d     = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = i_addr;
            mem_wdata_d = 64'd0;
            mem_tam_d   = 2'b00;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY_I, BUSY_D: begin
        // An ack wins over the timeout when both land in the same cycle
        if (mem_ack) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          err_d     = 1'b0;
          if (state_q == BUSY_I) begin
            i_done_d  = 1'b1;
            i_rdata_d = mem_rdata;
          end else begin
            d_done_d  = 1'b1;
            d_rdata_d = mem_rdata;
          end
        end else if (cnt_q == TIMEOUT_C) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          if (state_q == BUSY_I) begin
            i_done_d  = 1'b1;
            i_rdata_d = 64'd0;
          end else begin
            d_done_d  = 1'b1;
            d_rdata_d = 64'd0;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        last_d  = d_done_q ? PORT_D : PORT_I;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign i_gnt     = i_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_tam   = mem_tam_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a timestamp-based transaction model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_mem_arbiter;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we, mem_ack;
  logic [31:0] i_addr, d_addr;
  logic [63:0] d_wdata, mem_rdata;
  logic [1:0]  d_tam;
  logic        i_gnt, i_done, d_gnt, d_done, mem_req, mem_we, err, busy;
  logic [63:0] i_rdata, d_rdata, mem_wdata;
  logic [31:0] mem_addr;
  logic [1:0]  mem_tam;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // memory responder controls
  int          ack_k = 2;
  bit          stray = 1'b0;
  logic [63:0] rdata_val = 64'd0;
  int          age = 0;

  // scenario observations
  int f_ig, f_dg, idn_cyc, ddn_cyc, n_done, n_mreq, n0;
  logic idn_err, ddn_err;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_tam(d_tam),
    .d_gnt(d_gnt), .d_rdata(d_rdata), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_tam(mem_tam), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Memory: ack in the ack_k-th cycle of mem_req (0 = never), or whenever stray is set
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 64'd0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_req) age++;
      else age = 0;
      mem_ack   = (mem_req && ack_k != 0 && age == ack_k) || stray;
      mem_rdata = mem_ack ? rdata_val : 64'd0;
    end
  end

  // Transaction model: an access is a (port, start cycle, end cycle) record
  initial begin
    int          c, m_start, m_end, m_port;
    bit          m_active, m_tout, m_last_d, e_busy, e_mreq, e_end;
    logic [31:0] m_addr;
    logic        m_we;
    logic [63:0] m_wdata, m_irdata, m_drdata;
    logic [1:0]  m_tam;
    m_active = 1'b0; m_tout = 1'b0; m_last_d = 1'b0;
    m_start = 0; m_end = -1; m_port = 0;
    m_addr = 32'd0; m_we = 1'b0; m_wdata = 64'd0; m_tam = 2'b00;
    m_irdata = 64'd0; m_drdata = 64'd0;
    forever begin
      @(negedge clk);
      c = cyc;
      if (!rst) begin
        m_active = 1'b0; m_last_d = 1'b0;
        m_irdata = 64'd0; m_drdata = 64'd0;
      end
      e_busy = m_active && (c >= m_start);
      e_mreq = e_busy && (m_end < 0 || c < m_end);
      e_end  = m_active && (c == m_end);
      check("i_gnt",   64'(i_gnt),   64'(m_active && m_port == 1 && c == m_start));
      check("d_gnt",   64'(d_gnt),   64'(m_active && m_port == 2 && c == m_start));
      check("i_done",  64'(i_done),  64'(e_end && m_port == 1));
      check("d_done",  64'(d_done),  64'(e_end && m_port == 2));
      check("err",     64'(err),     64'(e_end && m_tout));
      check("busy",    64'(busy),    64'(e_busy));
      check("mem_req", 64'(mem_req), 64'(e_mreq));
      check("i_rdata", i_rdata, m_irdata);
      check("d_rdata", d_rdata, m_drdata);
      if (e_mreq) begin
        check("mem_we",   64'(mem_we),   64'(m_we));
        check("mem_addr", 64'(mem_addr), 64'(m_addr));
        check("mem_tam",  64'(mem_tam),  64'(m_tam));
        if (m_port == 2) check("mem_wdata", mem_wdata, m_wdata);
      end
      if (rst) begin
        if (e_end) begin
          m_last_d = (m_port == 2);
          m_active = 1'b0;
        end else if (m_active) begin
          if (m_end < 0) begin
            if (mem_ack) begin
              m_end = c + 1; m_tout = 1'b0;
              if (m_port == 1) m_irdata = mem_rdata; else m_drdata = mem_rdata;
            end else if (c - m_start == TO) begin
              m_end = c + 1; m_tout = 1'b1;
              if (m_port == 1) m_irdata = 64'd0; else m_drdata = 64'd0;
            end
          end
        end else if (i_req || d_req) begin
          m_active = 1'b1; m_start = c + 1; m_end = -1;
          if (d_req && (!i_req || !m_last_d)) begin
            m_port = 2; m_addr = d_addr; m_we = d_we; m_wdata = d_wdata; m_tam = d_tam;
          end else begin
            m_port = 1; m_addr = i_addr; m_we = 1'b0; m_tam = 2'b00;
          end
        end
      end
    end
  end

  task automatic clear();
    f_ig = -1; f_dg = -1; idn_cyc = -1; ddn_cyc = -1; n_done = 0; n_mreq = 0;
  endtask

  // One cycle as seen by both requesters: observe, then drop req after a done
  task automatic tick();
    bit si, sd;
    @(negedge clk);
    si = i_done; sd = d_done;
    if (i_gnt && f_ig < 0) f_ig = cyc;
    if (d_gnt && f_dg < 0) f_dg = cyc;
    if (i_done) begin idn_cyc = cyc; idn_err = err; n_done++; end
    if (d_done) begin ddn_cyc = cyc; ddn_err = err; n_done++; end
    if (mem_req) n_mreq++;
    @(posedge clk);
    #1;
    if (si) i_req = 1'b0;
    if (sd) d_req = 1'b0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = 32'd0; d_addr = 32'd0; d_wdata = 64'd0; d_tam = 2'b00;
    clear();
    run(3);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    rst = 1'b1;
    run(2);

    // Tie straight after reset: D first, then I in the IDLE after d_done
    clear(); rdata_val = 64'h1111; i_addr = 32'h80; d_addr = 32'h300;
    i_req = 1'b1; d_req = 1'b1; n0 = cyc;
    run(12);
    check("tie1_d_first", 64'(f_dg), 64'(n0 + 1));
    check("tie1_d_done", 64'(ddn_cyc), 64'(n0 + 3));
    check("tie1_i_after", 64'(f_ig), 64'(n0 + 5));
    check("tie1_i_done", 64'(idn_cyc), 64'(n0 + 7));

    // Second tie after I was served last: D again
    clear(); rdata_val = 64'h2222;
    i_req = 1'b1; d_req = 1'b1; n0 = cyc;
    run(12);
    check("tie2_d_first", 64'(f_dg), 64'(n0 + 1));
    check("tie2_i_after", 64'(f_ig), 64'(n0 + 5));

    // Fetch only, ack one cycle after mem_req
    clear(); rdata_val = 64'h00A00093; i_addr = 32'h40;
    i_req = 1'b1; n0 = cyc;
    run(6);
    check("fetch_gnt", 64'(f_ig), 64'(n0 + 1));
    check("fetch_done", 64'(idn_cyc), 64'(n0 + 3));
    check("fetch_rdata", i_rdata, 64'h00A00093);
    check("fetch_err", 64'(idn_err), 64'd0);

    // Store: requester inputs change mid-access, memory port must hold
    clear(); rdata_val = 64'h1234; ack_k = 5;
    d_we = 1'b1; d_tam = 2'b11; d_addr = 32'h100; d_wdata = 64'hFF;
    d_req = 1'b1; n0 = cyc;
    run(2);
    d_addr = 32'h200; d_wdata = 64'hAA; d_tam = 2'b00; d_we = 1'b0;
    tick();
    check("store_addr", 64'(mem_addr), 64'h100);
    check("store_we", 64'(mem_we), 64'd1);
    check("store_tam", 64'(mem_tam), 64'd3);
    check("store_wdata", mem_wdata, 64'hFF);
    run(6);
    check("store_done", 64'(ddn_cyc), 64'(n0 + 6));

    // Timeout: memory never acks
    clear(); ack_k = 0; d_addr = 32'h180;
    d_req = 1'b1; n0 = cyc;
    run(22);
    check("tout_mreq_cycles", 64'(n_mreq), 64'd16);
    check("tout_done", 64'(ddn_cyc), 64'(n0 + 17));
    check("tout_err", 64'(ddn_err), 64'd1);
    check("tout_rdata", d_rdata, 64'd0);

    // Ack in the very cycle the counter reaches TIMEOUT
    clear(); ack_k = 16; rdata_val = 64'hCAFEF00D00000001;
    d_req = 1'b1; n0 = cyc;
    run(22);
    check("bound_mreq_cycles", 64'(n_mreq), 64'd16);
    check("bound_done", 64'(ddn_cyc), 64'(n0 + 17));
    check("bound_err", 64'(ddn_err), 64'd0);
    check("bound_rdata", d_rdata, 64'hCAFEF00D00000001);

    // Stray ack while IDLE
    clear(); stray = 1'b1;
    run(4);
    stray = 1'b0;
    run(2);
    check("stray_no_done", 64'(n_done), 64'd0);

    // Reset during BUSY_D, then a tie must go to D again
    clear(); ack_k = 0; d_req = 1'b1;
    run(3);
    rst = 1'b0; i_req = 1'b1;
    #1;
    check("rst_mid_mreq", 64'(mem_req), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    run(2);
    check("rst_mid_no_done", 64'(ddn_cyc), 64'hFFFFFFFFFFFFFFFF);
    clear(); ack_k = 2; rdata_val = 64'h3333;
    rst = 1'b1; n0 = cyc;
    run(12);
    check("post_rst_d_first", 64'(f_dg), 64'(n0 + 1));
    check("post_rst_i_after", 64'(f_ig), 64'(n0 + 5));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum number of BUSY cycles allowed without mem_ack before the access is aborted; range 1..15.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 rst  in  1  asynchronous reset, active-low.
REQ-004 i_req  in  1  fetch read request, held high until i_done.
REQ-005 i_addr  in  32  fetch address.
REQ-006 i_gnt  out  1  fetch access granted.
REQ-007 i_rdata  out  64  fetch read data.
REQ-008 i_done  out  1  fetch response strobe.
REQ-009 d_req  in  1  data request, held high until d_done.
REQ-010 d_we  in  1  data request is a write.
REQ-011 d_addr  in  32  data address.
REQ-012 d_wdata  in  64  data write value.
REQ-013 d_tam  in  2  store size: 00 double, 01 word, 10 half, 11 byte.
REQ-014 d_gnt, d_rdata (64), d_done  out  data grant, read data and response strobe.
REQ-015 mem_req, mem_we, mem_addr (32), mem_wdata (64), mem_tam (2)  out  shared memory port.
REQ-016 mem_rdata  in  64  memory read data, valid with mem_ack.
REQ-017 mem_ack  in  1  memory completes the current access.
REQ-018 err  out  1  aborted-access flag, valid with a done strobe.
REQ-019 busy  out  1  high whenever state is not IDLE.

Function
REQ-020 FSM states shall be IDLE, BUSY_I, BUSY_D and RESP; every output shall be registered.
REQ-021 Requests shall be sampled only in IDLE; a request seen in IDLE shall move the FSM to BUSY_I or BUSY_D on the next edge.
REQ-022 Ties shall be resolved round-robin against a last-grant pointer: when both requests are high, grant the port not served last; after reset the pointer shall be I, so D wins the first tie.
REQ-023 On entering BUSY_x:
  - x_gnt shall be high for exactly that first BUSY cycle.
  - addr, we, wdata and tam shall be captured into internal registers.
  - mem_req shall go high.
  - the timeout counter shall clear to 0.
REQ-024 Throughout BUSY, mem_* shall be driven from the captured registers; later changes on requester inputs shall have no effect.
REQ-025 A fetch access shall drive mem_we=0 and mem_tam=00; a data access shall drive mem_we=d_we and mem_tam=d_tam.
REQ-026 In BUSY, each cycle without mem_ack shall increment the 4-bit counter.
REQ-027 mem_ack high in BUSY shall cause, on the next edge:
  - move to RESP;
  - drop mem_req;
  - load mem_rdata into x_rdata (writes load it too; the value is don't-care to requesters);
  - set err=0.
REQ-028 If the counter equals TIMEOUT with no mem_ack, the next edge shall move to RESP, drop mem_req, load x_rdata=0 and set err=1.
REQ-029 mem_ack in the same cycle the counter reaches TIMEOUT shall complete normally (err=0).
REQ-030 In RESP, x_done shall be high for exactly one cycle; the next state shall be IDLE; the last-grant pointer shall update to x.
REQ-031 A requester shall drop its req at the edge where it samples done high; the arbiter therefore sees req low in the following IDLE cycle.
REQ-032 x_rdata shall hold its value until the next response to the same port.
REQ-033 mem_ack outside BUSY shall be ignored.
REQ-034 Latency:
  - req high in IDLE at cycle N gives gnt and mem_req at N+1.
  - mem_ack at cycle M gives done at M+1.
  - minimum latency from req to done is 3 cycles.
REQ-035 err shall be 0 in every cycle without a done strobe.

Reset
REQ-036 rst low shall immediately force the following, regardless of state:
  - state to IDLE and the last-grant pointer to I;
  - mem_req, mem_we, i_gnt, d_gnt, i_done, d_done, err and busy to 0;
  - mem_addr, mem_wdata, mem_tam, i_rdata, d_rdata and the counter to 0.
REQ-037 Reset mid-access shall abandon the access with no done strobe; the first edge after rst rises shall evaluate IDLE normally.

Verification
REQ-038 Fetch only: i_req=1, i_addr=0x40; mem_ack one cycle after mem_req with mem_rdata=0x00A00093 -> i_gnt at N+1, i_done at N+3, i_rdata=0x00A00093, err=0.
REQ-039 Tie after reset: i_req and d_req high together -> D served first; I granted in the IDLE cycle after d_done; a second tie after the I service grants D.
REQ-040 Store hold: d_we=1, d_tam=11, d_addr=0x100, d_wdata=0xFF; d_addr changed to 0x200 during BUSY -> mem_addr stays 0x100, mem_we=1, mem_tam=11 until mem_ack.
REQ-041 Timeout: TIMEOUT=15 with mem_ack never asserted -> mem_req high for 16 cycles, then d_done=1, err=1, d_rdata=0.
REQ-042 Boundary: mem_ack in the cycle the counter reaches 15 -> err=0 and rdata loaded; a stray mem_ack in IDLE -> no done strobe.
REQ-043 Reset: rst pulsed low during BUSY_D -> mem_req and busy drop the same cycle, no done strobe; the next tie grants D.
